// File: rtl/goa_cmd_ctrl.sv
// Byte-oriented host command controller for the GOA compute core.
// Decodes WRITE/READ/START/STATUS command bytes, drives the core's config
// and result ports, supervises a compute run with a cycle timeout and keeps
// sticky done/err/timeout flags that a STATUS read reports and clears.
module goa_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] cfg_addr,
    output logic [7:0] cfg_wdata,
    output logic       cfg_we,
    output logic [3:0] res_addr,
    input  logic [7:0] res_rdata,
    output logic       core_start,
    input  logic       core_busy,
    input  logic       core_done
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_READ   = 4'h2;
    localparam logic [3:0] OP_START  = 4'h3;
    localparam logic [3:0] OP_STATUS = 4'h4;

    typedef enum logic [2:0] {IDLE, WDATA, RD, SEND, RUN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] run_cnt;
    logic             done_q, err_q, timeout_q;
    logic             accept;
    logic             run_last;
    logic [3:0]       opcode, arg;

    // Reset forces in_ready low in the reset cycle itself, not just after it.
    assign in_ready  = !rst && (state == IDLE || state == WDATA);
    assign out_valid = (state == SEND);
    assign accept    = in_valid & in_ready;
    assign opcode    = in_data[7:4];
    assign arg       = in_data[3:0];
    assign run_last  = (run_cnt == RUN_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_WRITE:  state_nxt = WDATA;
                        OP_READ:   state_nxt = RD;
                        OP_START:  state_nxt = core_busy ? IDLE : RUN;
                        OP_STATUS: state_nxt = SEND;
                        default:   state_nxt = IDLE;
                    endcase
                end
            end
            WDATA:   if (accept) state_nxt = IDLE;
            RD:      state_nxt = SEND;
            SEND:    if (out_ready) state_nxt = IDLE;
            // core_done on the last allowed cycle still ends the run normally
            RUN:     if (core_done || run_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers, one-cycle strobes and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            cfg_addr   <= '0;
            cfg_wdata  <= '0;
            cfg_we     <= 1'b0;
            res_addr   <= '0;
            core_start <= 1'b0;
            run_cnt    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            cfg_we     <= 1'b0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_WRITE: cfg_addr <= arg;
                            OP_READ:  res_addr <= arg;
                            OP_START: begin
                                if (core_busy) begin
                                    err_q <= 1'b1;
                                end else begin
                                    core_start <= 1'b1;
                                    run_cnt    <= '0;
                                end
                            end
                            OP_STATUS: begin
                                // snapshot then clear; flags set later are kept
                                out_data  <= {core_busy, done_q, err_q, timeout_q, 4'b0000};
                                done_q    <= 1'b0;
                                err_q     <= 1'b0;
                                timeout_q <= 1'b0;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                WDATA: begin
                    if (accept) begin
                        cfg_wdata <= in_data;
                        cfg_we    <= 1'b1;
                    end
                end
                RD: out_data <= res_rdata;
                RUN: begin
                    if (core_done)     done_q    <= 1'b1;
                    else if (run_last) timeout_q <= 1'b1;
                    else               run_cnt   <= run_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_goa_cmd_ctrl.sv
// Bench for goa_cmd_ctrl: reset checks, a table of single-command vectors,
// randomized command streams against a transaction-level flag model, and
// hand sequences for run timeout, read back-pressure and mid-operation reset.
module tb_goa_cmd_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_we;
    logic [3:0] res_addr;
    logic [7:0] res_rdata;
    logic       core_start;
    logic       core_busy = 1'b0;
    logic       core_done = 1'b0;

    logic [7:0] res_mem [16];
    assign res_rdata = res_mem[res_addr];

    always #5 clk = ~clk;

    goa_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_we(cfg_we),
        .res_addr(res_addr), .res_rdata(res_rdata),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done)
    );

    int nvec = 0;
    int nbad = 0;
    int n_we = 0;
    int n_start = 0;
    int exp_we = 0;
    int exp_start = 0;
    logic m_done = 1'b0, m_err = 1'b0, m_to = 1'b0;

    // Count strobe cycles; a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (cfg_we === 1'b1)     n_we    <= n_we + 1;
        if (core_start === 1'b1) n_start <= n_start + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a byte until accepted; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            cyc();
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", in_ready, 1);
        cyc();
        in_valid = 1'b0;
    endtask

    // Wait for a response, hold off out_ready, then take it.
    task automatic get_resp(input string nm, input logic [7:0] exp, input int hold, output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            cyc();
            @(negedge clk);
            lat++;
        end
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_data"}, out_data, exp);
        for (int i = 0; i < hold; i++) begin
            cyc();
            @(negedge clk);
            chk({nm, "_hold"}, {out_valid, out_data}, {1'b1, exp});
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_after"}, {out_valid, in_ready}, 2'b01);
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_in_ready", in_ready, 0);
        cyc();
        rst = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_to = 1'b0;
        @(negedge clk);
        chk("rst_outputs",
            {out_valid, out_data, cfg_addr, cfg_wdata, cfg_we, res_addr, core_start, in_ready},
            {1'b0, 8'h00, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1});
        cyc();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        send_byte({4'h1, a});
        send_byte(d);
        exp_we++;
        @(negedge clk);
        chk("wr_strobe", {cfg_we, cfg_addr, cfg_wdata}, {1'b1, a, d});
        cyc();
        @(negedge clk);
        chk("wr_once", {cfg_we, cfg_addr, cfg_wdata}, {1'b0, a, d});
        cyc();
        chk("wr_count", n_we, exp_we);
    endtask

    task automatic do_read(input logic [3:0] a, input int hold);
        int lat;
        send_byte({4'h2, a});
        get_resp("rd", res_mem[a], hold, lat);
        chk("rd_latency", lat, 1);
    endtask

    task automatic do_status(input logic busy, input int hold);
        int lat;
        logic [7:0] exp;
        exp = {busy, m_done, m_err, m_to, 4'b0000};
        core_busy = busy;
        send_byte({4'h4, 4'($urandom)});
        core_busy = 1'b0;
        m_done = 1'b0; m_err = 1'b0; m_to = 1'b0;
        get_resp("status", exp, hold, lat);
    endtask

    // Called in RUN cycle 0; pulses core_done in cycle d (d>=TO lands in IDLE).
    task automatic run_core(input int d, output int low);
        low = 0;
        for (int k = 0; k < 21; k++) begin
            core_done = (k == d);
            @(negedge clk);
            if (k == 0) chk("start_pulse", core_start, 1);
            if (k == 1) chk("start_once", core_start, 0);
            if (!in_ready) low++;
            cyc();
        end
        core_done = 1'b0;
    endtask

    task automatic do_start(input logic busy, input int d);
        int low;
        if (busy) begin
            core_busy = 1'b1;
            send_byte({4'h3, 4'($urandom)});
            core_busy = 1'b0;
            m_err = 1'b1;
            @(negedge clk);
            chk("busy_start", {core_start, in_ready}, 2'b01);
            cyc();
        end else begin
            send_byte({4'h3, 4'($urandom)});
            run_core(d, low);
            exp_start++;
            chk("run_len", low, (d < TO) ? d + 1 : TO);
            if (d < TO) m_done = 1'b1;
            else        m_to = 1'b1;
        end
        chk("start_count", n_start, exp_start);
    endtask

    task automatic do_bad();
        int op;
        op = $urandom_range(5, 16);
        if (op == 16) op = 0;
        send_byte({4'(op), 4'($urandom)});
        m_err = 1'b1;
        @(negedge clk);
        chk("bad_op", {out_valid, in_ready}, 2'b01);
        cyc();
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic       busy;
        logic       has_resp;
        logic [7:0] resp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int lat, low;
        vec_t v;

        for (int i = 0; i < 16; i++) res_mem[i] = 8'($urandom);
        res_mem[3]  = 8'h5C;
        res_mem[15] = 8'hE1;

        tbl[0]  = '{8'h15, 8'hA7, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{8'h23, 8'h00, 1'b0, 1'b1, 8'h5C};
        tbl[2]  = '{8'h2F, 8'h00, 1'b0, 1'b1, 8'hE1};
        tbl[3]  = '{8'h40, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[4]  = '{8'h30, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{8'h9F, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{8'h40, 8'h00, 1'b1, 1'b1, 8'hA0};
        tbl[7]  = '{8'h40, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[8]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{8'h4F, 8'h00, 1'b1, 1'b1, 8'hA0};
        tbl[10] = '{8'h57, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{8'h40, 8'h00, 1'b0, 1'b1, 8'h20};
        tbl[12] = '{8'h1C, 8'h3E, 1'b0, 1'b0, 8'h00};

        cyc();
        cyc();
        do_reset();

        // Table of single commands from a freshly reset controller
        for (int i = 0; i < 13; i++) begin
            v = tbl[i];
            if (v.b0[7:4] == 4'h1) begin
                do_write(v.b0[3:0], v.b1);
            end else begin
                core_busy = v.busy;
                send_byte(v.b0);
                core_busy = 1'b0;
                if (v.has_resp) begin
                    get_resp($sformatf("tbl%0d", i), v.resp, 0, lat);
                end else begin
                    @(negedge clk);
                    chk($sformatf("tbl%0d_noresp", i), {out_valid, in_ready, core_start}, 3'b010);
                    cyc();
                end
            end
            chk("tbl_we_count", n_we, exp_we);
            chk("tbl_start_count", n_start, exp_start);
        end

        // Randomized command stream against the flag model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: do_write(4'($urandom), 8'($urandom));
                1: begin
                    int a;
                    a = $urandom_range(0, 15);
                    res_mem[a] = 8'($urandom);
                    do_read(4'(a), $urandom_range(0, 2));
                end
                2: do_start($urandom_range(0, 3) == 0, $urandom_range(0, 20));
                3, 5: do_status(1'($urandom), $urandom_range(0, 2));
                default: do_bad();
            endcase
        end
        chk("rand_we_count", n_we, exp_we);

        // Read with back-pressure: response two cycles after accept, held stable
        do_reset();
        res_mem[3] = 8'h5C;
        send_byte(8'h23);
        @(negedge clk);
        chk("rd_cycle_no_valid", out_valid, 0);
        cyc();
        get_resp("bp_read", 8'h5C, 3, lat);
        chk("bp_read_latency", lat, 0);

        // Run completed by core_done after 10 cycles
        do_reset();
        send_byte(8'h30);
        run_core(9, low);
        exp_start++;
        chk("done_run_len", low, 10);
        chk("done_start_count", n_start, exp_start);
        send_byte(8'h40);
        get_resp("status_done", 8'h40, 0, lat);
        send_byte(8'h40);
        get_resp("status_done_clr", 8'h00, 0, lat);

        // Run timeout, done on the last cycle, done one cycle too late
        do_reset();
        send_byte(8'h30);
        run_core(99, low);
        chk("to_run_len", low, TO);
        send_byte(8'h40);
        get_resp("status_to", 8'h10, 0, lat);
        send_byte(8'h30);
        run_core(TO - 1, low);
        chk("last_done_run_len", low, TO);
        send_byte(8'h40);
        get_resp("status_last_done", 8'h40, 0, lat);
        send_byte(8'h30);
        run_core(TO, low);
        chk("late_done_run_len", low, TO);
        send_byte(8'h40);
        get_resp("status_late_done", 8'h10, 0, lat);
        exp_start += 3;
        chk("to_start_count", n_start, exp_start);

        // Reset in RUN, SEND and WDATA aborts with no late pulses or response
        do_reset();
        do_write(4'h5, 8'hA7);
        send_byte(8'h23);
        get_resp("pre_rst_read", 8'h5C, 0, lat);
        send_byte(8'h30);
        exp_start++;
        cyc();
        cyc();
        cyc();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            core_done = (i == 4);
            cyc();
        end
        core_done = 1'b0;
        chk("rst_run_start_count", n_start, exp_start);
        do_status(1'b0, 0);

        send_byte(8'h2F);
        cyc();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_send_no_valid", out_valid, 0);
            cyc();
        end

        send_byte(8'h1A);
        do_reset();
        cyc();
        cyc();
        chk("rst_wdata_no_we", n_we, exp_we);
        chk("rst_wdata_addr", cfg_addr, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/goa_cmd_ctrl.md
GOA_CMD_CTRL -- requirements
Module: goa_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: max RUN cycles before abort; legal range 2..65535.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_data  in  8  host command/data byte.
REQ-005 in_valid  in  1  in_data valid; already synchronous to clk.
REQ-006 in_ready  out  1  controller accepts byte; transfer when in_valid&in_ready.
REQ-007 out_data  out  8  response byte to host.
REQ-008 out_valid  out  1  out_data valid; transfer when out_valid&out_ready.
REQ-009 out_ready  in  1  host accepts response.
REQ-010 cfg_addr  out  4  config register address to core.
REQ-011 cfg_wdata  out  8  config write data.
REQ-012 cfg_we  out  1  one-cycle config write strobe.
REQ-013 res_addr  out  4  result register address; core returns res_rdata combinationally.
REQ-014 res_rdata  in  8  result read data.
REQ-015 core_start  out  1  one-cycle compute start pulse.
REQ-016 core_busy  in  1  core computing.
REQ-017 core_done  in  1  one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, WDATA, RD, SEND, RUN; at most one byte accepted per cycle.
REQ-019 IDLE: in_ready=1; accepted byte decoded by opcode in_data[7:4], argument in_data[3:0].
REQ-020 Opcode 0x1 (WRITE): latch cfg_addr=arg, go WDATA.
REQ-021 WDATA: in_ready=1; on accept, cfg_wdata=byte, cfg_we=1 for exactly the following cycle, go IDLE; byte content not decoded.
REQ-022 Opcode 0x2 (READ): res_addr=arg, go RD; RD captures res_rdata into out_data, go SEND (response out_valid 2 cycles after accept).
REQ-023 Opcode 0x3 (START): if core_busy=0, core_start=1 for one cycle, clear run counter, go RUN; if core_busy=1, set err sticky, stay IDLE, no pulse.
REQ-024 Opcode 0x4 (STATUS): out_data={core_busy,done,err,timeout,4'b0000} sampled at accept, then done/err/timeout cleared; go SEND.
REQ-025 Any other opcode: set err sticky, stay IDLE.
REQ-026 SEND: in_ready=0, out_valid=1, out_data stable until out_ready=1; on transfer go IDLE with out_valid=0 next cycle.
REQ-027 RUN: in_ready=0; run counter increments each cycle; core_done=1 sets done sticky and goes IDLE.
REQ-028 RUN: counter reaching TIMEOUT_CYCLES-1 without core_done sets timeout sticky, goes IDLE; core_done on same cycle wins (done set, timeout not).
REQ-029 core_done outside RUN SHALL be ignored; core_busy affects only START and status.
REQ-030 cfg_addr, res_addr, cfg_wdata hold last value when not updated.
REQ-031 Run counter width ceil(log2(TIMEOUT_CYCLES)); no wrap inside RUN.

Reset
REQ-032 rst=1 at clock edge: state IDLE; in_ready=0 during reset cycle, 1 in first cycle after release.
REQ-033 Reset values: out_data=0, out_valid=0, cfg_addr=0, cfg_wdata=0, cfg_we=0, res_addr=0, core_start=0, done=err=timeout=0, run counter=0.
REQ-034 rst during WDATA/SEND/RUN SHALL abort operation with no cfg_we/core_start pulse and discard pending response.

Verification
REQ-035 Bytes 0x15,0xA7 -> one cycle cfg_we=1, cfg_addr=5, cfg_wdata=0xA7; no other cfg_we.
REQ-036 Byte 0x23, res_rdata=0x5C, out_ready held 0 for 3 cycles -> out_valid=1, out_data=0x5C stable throughout; single transfer, then in_ready=1.
REQ-037 Byte 0x30, core_busy=0, core_done after 10 cycles; then 0x40 -> one core_start pulse; status 0x40 (done); second 0x40 -> 0x00.
REQ-038 TIMEOUT_CYCLES=16, 0x30, no core_done -> IDLE after 16 RUN cycles; 0x40 -> 0x10; core_done exactly on final cycle variant -> 0x40.
REQ-039 Byte 0x30 with core_busy=1, then 0x9F, then 0x40 -> no core_start; status 0xA0 (busy, err).
REQ-040 rst asserted in RUN and in SEND -> all outputs at REQ-033 values next cycle; no late pulses.
